// File: rtl/conv1d_layer_pkg.sv
// Shared types and helpers for the streaming 1-D convolution layer.
// Holds the FSM state encoding, the word type and the saturation/address-width helpers.
package conv1d_layer_pkg;

    localparam int unsigned WORD_SIZE = 16;
    // Wide enough to carry any accumulator of this layer into saturation.
    localparam int unsigned SAT_W = 64;

    typedef logic signed [WORD_SIZE-1:0] word_t;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StMac,
        StOut
    } state_e;

    // Width of the word_addr field: kernel weights plus one bias slot.
    function automatic int unsigned word_addr_w(input int unsigned kernel_words);
        return $clog2(kernel_words + 1);
    endfunction

    // Width of the mem_index field: index 0 is reserved, kernels start at 1.
    function automatic int unsigned mem_index_w(input int unsigned n_conv);
        return $clog2(n_conv + 1);
    endfunction

    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                         input int unsigned ws);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (ws - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/conv_kernel_mac.sv
// One convolution kernel: weight/bias RAM, sequential multiply-accumulate and
// saturated result register.
module conv_kernel_mac
    import conv1d_layer_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned N_SIZE       = 0,
    parameter int unsigned KERNEL_WORDS = 6,
    parameter int unsigned AW           = word_addr_w(KERNEL_WORDS)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic                 last_i,
    input  logic [AW-1:0]        idx_i,
    input  logic [WORD_SIZE-1:0] win_i,
    output logic [WORD_SIZE-1:0] result_o
);

    localparam int unsigned ACC_W = 2 * WORD_SIZE + $clog2(KERNEL_WORDS + 1) + N_SIZE;
    localparam logic [AW-1:0] BiasAddr = AW'(KERNEL_WORDS);

    logic [WORD_SIZE-1:0]        mem_q [KERNEL_WORDS+1];
    logic signed [2*WORD_SIZE-1:0] prod;
    logic signed [ACC_W-1:0]     bias_acc;
    logic signed [ACC_W-1:0]     acc_q;
    logic signed [ACC_W-1:0]     acc_next;
    logic signed [ACC_W-1:0]     acc_shift;
    logic signed [SAT_W-1:0]     sat_val;
    logic [WORD_SIZE-1:0]        result_q;

    // Weight memory has no reset; it keeps its contents across frame aborts.
    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i <= BiasAddr)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        prod      = $signed(mem_q[idx_i]) * $signed(win_i);
        bias_acc  = ACC_W'($signed(mem_q[BiasAddr])) <<< N_SIZE;
        acc_next  = acc_q + ACC_W'(prod);
        acc_shift = acc_next >>> N_SIZE;
        sat_val   = saturate(SAT_W'(acc_shift), WORD_SIZE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            if (clear_i) begin
                acc_q <= bias_acc;
            end else if (en_i) begin
                acc_q <= acc_next;
            end
            // The final product is folded in on the same edge the result is captured.
            if (last_i) begin
                result_q <= sat_val[WORD_SIZE-1:0];
            end
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/conv1d_layer.sv
// Streaming 1-D convolution layer: frame FSM, row window shift register and
// valid/ready handshakes around N_CONVOLUTIONS kernel MAC units.
module conv1d_layer
    import conv1d_layer_pkg::*;
#(
    parameter int unsigned INPUT_LAYER_HEIGHT = 5,
    parameter int unsigned KERNEL_HEIGHT      = 3,
    parameter int unsigned KERNEL_WIDTH       = 2,
    parameter int unsigned WORD_SIZE          = 16,
    parameter int unsigned N_SIZE             = 0,
    parameter int unsigned LAYER_NUMBER       = 1,
    parameter int unsigned N_CONVOLUTIONS     = 1,
    localparam int unsigned ADDR_W = mem_index_w(N_CONVOLUTIONS) +
                                     word_addr_w(KERNEL_HEIGHT * KERNEL_WIDTH)
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                start_i,
    input  logic                                valid_i,
    output logic                                yumi_o,
    input  logic [WORD_SIZE-1:0]                data_i,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic [N_CONVOLUTIONS*WORD_SIZE-1:0] data_o,
    input  logic                                wen_i,
    input  logic [ADDR_W-1:0]                   mem_addr_i,
    input  logic [WORD_SIZE-1:0]                mem_data_i
);

    localparam int unsigned KWORDS = KERNEL_HEIGHT * KERNEL_WIDTH;
    localparam int unsigned AW     = word_addr_w(KWORDS);
    localparam int unsigned IW     = mem_index_w(N_CONVOLUTIONS);
    localparam int unsigned N_OUT  = INPUT_LAYER_HEIGHT - KERNEL_HEIGHT + 1;
    localparam int unsigned RW     = $clog2(N_OUT + 1);

    state_e               state_q, state_d;
    logic [AW-1:0]        need_q, need_d;
    logic [RW-1:0]        rows_q, rows_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [WORD_SIZE-1:0] window_q [KWORDS];
    logic                 mac_clear;
    logic                 mac_en;
    logic                 mac_last;
    logic [IW-1:0]        mem_index;
    logic [AW-1:0]        word_addr;
    logic [WORD_SIZE-1:0] win_word;

    assign mem_index = mem_addr_i[ADDR_W-1 -: IW];
    assign word_addr = mem_addr_i[AW-1:0];
    assign win_word  = window_q[idx_q];
    assign valid_o   = (state_q == StOut);

    always_comb begin
        state_d   = state_q;
        need_d    = need_q;
        rows_d    = rows_q;
        idx_d     = idx_q;
        yumi_o    = 1'b0;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        mac_last  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLoad;
                    need_d  = AW'(KWORDS);
                    rows_d  = '0;
                end
            end
            StLoad: begin
                yumi_o = valid_i;
                if (valid_i) begin
                    need_d = need_q - AW'(1);
                    if (need_q == AW'(1)) begin
                        state_d   = StMac;
                        idx_d     = '0;
                        mac_clear = 1'b1;
                    end
                end
            end
            StMac: begin
                mac_en = 1'b1;
                idx_d  = idx_q + AW'(1);
                if (idx_q == AW'(KWORDS - 1)) begin
                    mac_last = 1'b1;
                    state_d  = StOut;
                end
            end
            StOut: begin
                if (ready_i) begin
                    rows_d = rows_q + RW'(1);
                    if (rows_q == RW'(N_OUT - 1)) begin
                        state_d = StIdle;
                    end else begin
                        // Later vectors only need one fresh row in the window.
                        state_d = StLoad;
                        need_d  = AW'(KERNEL_WIDTH);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            need_q  <= '0;
            rows_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            need_q  <= need_d;
            rows_q  <= rows_d;
            idx_q   <= idx_d;
        end
    end

    // Oldest word sits at index 0, so window index matches weight word_addr.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < KWORDS; i++) begin
                window_q[i] <= '0;
            end
        end else if (yumi_o) begin
            for (int i = 0; i < KWORDS - 1; i++) begin
                window_q[i] <= window_q[i+1];
            end
            window_q[KWORDS-1] <= data_i;
        end
    end

    for (genvar c = 0; c < N_CONVOLUTIONS; c++) begin : g_kernel
        logic                 we;
        logic [WORD_SIZE-1:0] result;

        assign we = wen_i && (mem_index == IW'(c + 1));

        conv_kernel_mac #(
            .WORD_SIZE    (WORD_SIZE),
            .N_SIZE       (N_SIZE),
            .KERNEL_WORDS (KWORDS),
            .AW           (AW)
        ) u_mac (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .we_i      (we),
            .waddr_i   (word_addr),
            .wdata_i   (mem_data_i),
            .clear_i   (mac_clear),
            .en_i      (mac_en),
            .last_i    (mac_last),
            .idx_i     (idx_q),
            .win_i     (win_word),
            .result_o  (result)
        );

        assign data_o[c*WORD_SIZE +: WORD_SIZE] = result;
    end

endmodule

// File: tb/tb_conv1d_layer.sv
// Scoreboard bench for conv1d_layer: frames are pushed through a behavioural
// convolution model and outputs are checked by an independent monitor.
module tb_conv1d_layer;
    import conv1d_layer_pkg::*;

    localparam int unsigned H   = 5;
    localparam int unsigned KH  = 3;
    localparam int unsigned KW  = 2;
    localparam int unsigned WS  = 16;
    localparam int unsigned NS  = 0;
    localparam int unsigned NF  = H * KW;
    localparam int unsigned NO  = H - KH + 1;

    typedef logic [15:0] frame_t [NF];

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        yumi_o;
    logic [15:0] data_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [15:0] data_o;
    logic        wen_i = 1'b0;
    logic [3:0]  mem_addr_i = '0;
    logic [15:0] mem_data_i = '0;

    int          total = 0;
    int          bad = 0;
    int          ready_mode = 0;
    logic [15:0] exp_q [$];
    logic [15:0] model_w [KH*KW+1];
    logic [15:0] last_exp = '0;
    frame_t      f1, f2, fr;

    conv1d_layer #(
        .INPUT_LAYER_HEIGHT (H),
        .KERNEL_HEIGHT      (KH),
        .KERNEL_WIDTH       (KW),
        .WORD_SIZE          (WS),
        .N_SIZE             (NS),
        .LAYER_NUMBER       (1),
        .N_CONVOLUTIONS     (1)
    ) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .start_i    (start_i),
        .valid_i    (valid_i),
        .yumi_o     (yumi_o),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .wen_i      (wen_i),
        .mem_addr_i (mem_addr_i),
        .mem_data_i (mem_data_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each output row o is bias + sum of kernel(r,k) * input(o+r,k).
    function automatic void push_expected(input frame_t x);
        longint acc;
        for (int o = 0; o < NO; o++) begin
            acc = longint'($signed(model_w[KH*KW])) <<< NS;
            for (int r = 0; r < KH; r++) begin
                for (int k = 0; k < KW; k++) begin
                    acc += longint'($signed(model_w[r*KW+k])) *
                           longint'($signed(x[(o+r)*KW+k]));
                end
            end
            acc = acc >>> NS;
            if (acc > 32767) acc = 32767;
            else if (acc < -32768) acc = -32768;
            exp_q.push_back(16'(acc));
            last_exp = 16'(acc);
        end
    endfunction

    task automatic write_mem(input int idx, input int addr, input logic [15:0] d);
        wen_i      = 1'b1;
        mem_addr_i = 4'((idx << 3) | addr);
        mem_data_i = d;
        @(posedge clk); #1;
        wen_i = 1'b0;
        if (idx == 1 && addr <= KH*KW) model_w[addr] = d;
    endtask

    task automatic load_kernel();
        int w [6] = '{1, 6, 1, 5, 2, 3};
        for (int i = 0; i < 6; i++) write_mem(1, i, 16'(w[i]));
        write_mem(1, 6, 16'h000F);
    endtask

    // Starts a frame and feeds nwords words, honouring yumi_o.
    task automatic send_frame(input frame_t x, input int nwords, input bit bubbles,
                              input bit noise);
        bit got;
        int i;
        int budget;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        i = 0;
        budget = 0;
        while (i < nwords && budget < 1000) begin
            data_i  = x[i];
            valid_i = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
            start_i = noise ? ($urandom_range(0, 7) == 0) : 1'b0;
            @(negedge clk);
            got = yumi_o;
            @(posedge clk); #1;
            if (got) i++;
            budget++;
        end
        valid_i = 1'b0;
        start_i = 1'b0;
        if (i < nwords) check("feed_timeout", i, nwords);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 1000) begin
            @(posedge clk);
            c++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic stall_test();
        bit          seen;
        logic [15:0] held;
        ready_mode = 2;
        ready_i    = 1'b0;
        seen       = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            seen = valid_o;
        end
        check("stall_seen_valid", seen, 1);
        held = data_o;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("stall_valid", valid_o, 1);
            check("stall_data", data_o, held);
            check("stall_yumi", yumi_o, 0);
        end
        @(posedge clk); #1;
        ready_i    = 1'b1;
        ready_mode = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 0) ready_i = 1'b1;
            else if (ready_mode == 1) ready_i = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: one pop per accepted output vector.
    initial begin
        bit xfer_prev;
        xfer_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                xfer_prev = 1'b0;
            end else begin
                if (xfer_prev) check("valid_gap", valid_o, 0);
                if (!valid_i) check("yumi_no_valid", yumi_o, 0);
                if (valid_o && ready_i) begin
                    if (exp_q.size() == 0) check("unexpected_out", 1, 0);
                    else check("data_o", data_o, exp_q.pop_front());
                end
                xfer_prev = valid_o && ready_i;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        f1 = '{16'd1, 16'd0, 16'd1, 16'd5, 16'd3, 16'd2, 16'd9, 16'd5, 16'd0, 16'd1};
        f2 = '{16'd4, 16'd3, 16'd3, 16'd1, 16'd1, 16'd2, 16'hF, 16'hF, 16'd5, 16'd6};
        for (int i = 0; i <= KH*KW; i++) model_w[i] = '0;

        repeat (3) @(posedge clk); #1;
        check("reset_valid_o", valid_o, 0);
        check("reset_yumi_o", yumi_o, 0);
        check("reset_data_o", data_o, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        load_kernel();
        // Writes to mem_index 0 and past the bias slot must be ignored.
        write_mem(0, 0, 16'h1234);
        write_mem(1, 7, 16'h5555);

        push_expected(f1);
        check("model_row0", exp_q[0], 16'h0036);
        send_frame(f1, NF, 1'b0, 1'b0);
        drain();

        push_expected(f2);
        send_frame(f2, NF, 1'b0, 1'b0);
        drain();

        push_expected(f1);
        fork
            send_frame(f1, NF, 1'b0, 1'b0);
            stall_test();
        join
        drain();

        ready_mode = 1;
        push_expected(f1);
        send_frame(f1, NF, 1'b1, 1'b1);
        drain();
        ready_mode = 0;

        for (int i = 0; i < KH*KW; i++) write_mem(1, i, 16'h7FFF);
        write_mem(1, KH*KW, 16'h0000);
        for (int i = 0; i < NF; i++) fr[i] = 16'h7FFF;
        push_expected(fr);
        send_frame(fr, NF, 1'b0, 1'b0);
        drain();
        for (int i = 0; i < NF; i++) fr[i] = 16'h8000;
        push_expected(fr);
        send_frame(fr, NF, 1'b0, 1'b0);
        drain();

        ready_mode = 1;
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i <= KH*KW; i++) begin
                if (t == 3) write_mem(1, i, 16'($urandom));
                else write_mem(1, i, 16'($urandom_range(0, 1023)) - 16'd512);
            end
            for (int i = 0; i < NF; i++) fr[i] = 16'($urandom_range(0, 1023)) - 16'd512;
            push_expected(fr);
            send_frame(fr, NF, 1'b1, 1'b1);
            drain();
        end
        ready_mode = 0;

        load_kernel();
        push_expected(f1);
        send_frame(f1, NF, 1'b0, 1'b0);
        drain();

        // Abort two cycles into the first MAC of a frame.
        send_frame(f1, KH*KW, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("hold_before_reset", data_o, last_exp);
        reset_n = 1'b0;
        #1;
        check("abort_valid_o", valid_o, 0);
        check("abort_data_o", data_o, 0);
        check("abort_yumi_o", yumi_o, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        push_expected(f1);
        send_frame(f1, NF, 1'b0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
